// File: rtl/mips_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: request size codes,
// responder FSM states and the byte width of each access size.
package mips_mem_pkg;

    localparam logic [1:0] SZ_ILLEGAL = 2'd0;
    localparam logic [1:0] SZ_WORD    = 2'd1;
    localparam logic [1:0] SZ_HALF    = 2'd2;
    localparam logic [1:0] SZ_HALFU   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Halfword stores use either half code, so both map to two bytes.
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SZ_WORD:           access_bytes = 3'd4;
            SZ_HALF, SZ_HALFU: access_bytes = 3'd2;
            default:           access_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Valid/ready request and response channel between a data-memory requester
// (master) and the memory-side responder (slave).
interface mips_dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/mips_dmem_responder_array.sv
// Big-endian byte-addressed data storage: byte-lane synchronous write and
// combinational word read at a word index. Lane 3 is the lowest byte address.
module mips_dmem_array #(
    parameter  int DEPTH_BYTES = 1024,
    localparam int IDX_W       = $clog2(DEPTH_BYTES / 4)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  logic [3:0]       wbe,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wbe[3 - l]) begin
                mem[{idx, 2'(l)}] <= wdata[8 * (3 - l) +: 8];
            end
        end
    end

    assign rdata = {mem[{idx, 2'd0}], mem[{idx, 2'd1}], mem[{idx, 2'd2}], mem[{idx, 2'd3}]};

endmodule

// File: rtl/mips_dmem_responder.sv
// Memory-side responder for the CPU data port: accepts one request at a time,
// waits WAIT_STATES cycles, then performs the access and holds the response.
module mips_dmem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_dmem_responder_if.slave  bus
);
    import mips_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_BYTES / 4);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    logic        accept;
    logic        go_resp;
    logic        acc_write;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [32:0] acc_end;
    logic        acc_err;
    logic [3:0]  lane_en;
    logic [3:0]  wbe;
    logic [31:0] lane_data;
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign accept = (state == IDLE) && req_ready_q && bus.req_valid;

    // With no wait states the access happens on the accept edge itself, so the
    // live request feeds the datapath while idle and the latched copy otherwise.
    assign acc_write = (state == IDLE) ? bus.req_write : lat_write;
    assign acc_size  = (state == IDLE) ? bus.req_size  : lat_size;
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

    assign go_resp = (WAIT_STATES == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));

    // The range check uses a 33-bit sum so addresses near 2^32 cannot wrap.
    always_comb begin
        acc_end = {1'b0, acc_addr} + {30'd0, access_bytes(acc_size)};
        acc_err = 1'b0;
        if (acc_size == SZ_ILLEGAL) begin
            acc_err = 1'b1;
        end else if ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end else if ((acc_size != SZ_WORD) && acc_addr[0]) begin
            acc_err = 1'b1;
        end else if (acc_end > 33'(DEPTH_BYTES)) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        if (acc_size == SZ_WORD) begin
            lane_en = 4'b1111;
        end else if (acc_addr[1]) begin
            lane_en = 4'b0011;
        end else begin
            lane_en = 4'b1100;
        end
    end

    assign lane_data = (acc_size == SZ_WORD) ? acc_wdata : {acc_wdata[15:0], acc_wdata[15:0]};
    assign wbe       = (go_resp && acc_write && !acc_err && reset) ? lane_en : 4'b0000;

    mips_dmem_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk   (clk),
        .idx   (acc_addr[IDX_W+1:2]),
        .wbe   (wbe),
        .wdata (lane_data),
        .rdata (rd_word)
    );

    assign rd_half = acc_addr[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_data = 32'd0;
        if (!acc_write && !acc_err) begin
            case (acc_size)
                SZ_WORD:  load_data = rd_word;
                SZ_HALF:  load_data = {{16{rd_half[15]}}, rd_half};
                SZ_HALFU: load_data = {16'd0, rd_half};
                default:  load_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            lat_write   <= 1'b0;
            lat_size    <= SZ_ILLEGAL;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write   <= bus.req_write;
                        lat_size    <= bus.req_size;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_data;
                            rsp_error_q <= acc_err;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (go_resp) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data;
                        rsp_error_q <= acc_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_error_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for two responders (2 wait states and 0 wait states) driven
// by directed and random traffic against a byte-array reference model.
module tb_mips_dmem_responder;
    import mips_mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   last_acc = 0;
    bit   rand_ready = 1'b0;
    bit   prev_v [2];
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] ref_mem [2][DEPTH];

    mips_dmem_responder_if a_if();
    mips_dmem_responder_if b_if();

    mips_dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );

    mips_dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got no event, required one within the cycle budget", name);
    endfunction

    // Reference: memory is a plain byte array; an access is nb consecutive bytes, MSB first.
    function automatic void model_access(input int d, input bit wr, input logic [1:0] sz,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int nb;
        nb  = (sz == SZ_WORD) ? 4 : ((sz == SZ_ILLEGAL) ? 0 : 2);
        rd  = 32'd0;
        if (nb == 0) err = 1'b1;
        else err = ((a % 32'(nb)) != 32'd0) || (({32'd0, a} + 64'(nb)) > 64'(DEPTH));
        if (err) return;
        for (int i = 0; i < nb; i++) begin
            if (wr) ref_mem[d][a + 32'(i)] = wd[8 * (nb - 1 - i) +: 8];
            else rd = (rd << 8) | {24'd0, ref_mem[d][a + 32'(i)]};
        end
        if (!wr && sz == SZ_HALF && rd[15]) rd = rd | 32'hFFFF_0000;
    endfunction

    task automatic set_req(input int d, input logic v, input logic w, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            a_if.req_valid = v; a_if.req_write = w; a_if.req_size = s;
            a_if.req_addr = a; a_if.req_wdata = wd;
        end else begin
            b_if.req_valid = v; b_if.req_write = w; b_if.req_size = s;
            b_if.req_addr = a; b_if.req_wdata = wd;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input int d, input bit wr, input logic [1:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        logic rdy;
        n = 0;
        set_req(d, 1'b1, wr, sz, a, wd);
        rdy = (d == 0) ? a_if.req_ready : b_if.req_ready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
            rdy = (d == 0) ? a_if.req_ready : b_if.req_ready;
        end
        if (!rdy) begin
            fail_now("req_accept_timeout");
            set_req(d, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            return;
        end
        model_access(d, wr, sz, a, wd, e.rdata, e.err);
        e.acc_cyc = cyc;
        last_acc  = cyc;
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
        @(negedge clk);
        set_req(d, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    task automatic rand_op(input int d);
        logic [31:0] a;
        logic [1:0]  s;
        bit          w;
        w = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 15) == 0) ? SZ_ILLEGAL : 2'($urandom_range(1, 3));
        case ($urandom_range(0, 9))
            0:       a = 32'($urandom_range(1016, 1040));
            1:       a = $urandom;
            2:       a = 32'($urandom_range(0, 1023));
            default: a = 32'($urandom_range(0, 1023)) & ((s == SZ_WORD) ? 32'hFFFF_FFFC : 32'hFFFF_FFFE);
        endcase
        apply_stimulus(d, w, s, a, $urandom);
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q_a.size() : q_b.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? q_a.size() : q_b.size()) != 0) begin
            fail_now("drain_timeout");
            if (d == 0) q_a.delete();
            else q_b.delete();
        end
    endtask

    task automatic monitor_step(input int d, input logic v, input logic rdy,
                                input logic [31:0] rd, input logic er);
        exp_t  e;
        string p;
        int    ws;
        if (d == 0) begin p = "a"; ws = WS_A; end
        else begin p = "b"; ws = WS_B; end
        if (v) begin
            if (((d == 0) ? q_a.size() : q_b.size()) == 0) begin
                fail_now({p, "_unexpected_rsp"});
            end else begin
                e = (d == 0) ? q_a[0] : q_b[0];
                if (!prev_v[d]) check_output({p, "_latency"}, 32'(cyc - e.acc_cyc), 32'(ws + 1));
                check_output({p, "_rdata"}, rd, e.rdata);
                check_output({p, "_error"}, {31'd0, er}, {31'd0, e.err});
                if (rdy) begin
                    if (d == 0) void'(q_a.pop_front());
                    else void'(q_b.pop_front());
                end
            end
        end
        prev_v[d] = v;
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            prev_v[0] = 1'b0;
            prev_v[1] = 1'b0;
        end else begin
            monitor_step(0, a_if.rsp_valid, a_if.rsp_ready, a_if.rsp_rdata, a_if.rsp_error);
            monitor_step(1, b_if.rsp_valid, b_if.rsp_ready, b_if.rsp_rdata, b_if.rsp_error);
        end
    end

    always @(negedge clk) begin
        if (rand_ready) a_if.rsp_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required completion within the time limit");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   first;
        set_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        a_if.rsp_ready = 1'b1;
        b_if.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_a_req_ready", {31'd0, a_if.req_ready}, 32'd1);
        check_output("rst_a_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd0);
        check_output("rst_a_rsp_rdata", a_if.rsp_rdata, 32'd0);
        check_output("rst_a_rsp_error", {31'd0, a_if.rsp_error}, 32'd0);
        check_output("rst_b_req_ready", {31'd0, b_if.req_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEPTH / 4; i++) apply_stimulus(0, 1'b1, SZ_WORD, 32'(i * 4), $urandom);
        wait_drain(0);
        for (int i = 0; i < DEPTH / 4; i++) apply_stimulus(1, 1'b1, SZ_WORD, 32'(i * 4), $urandom);
        wait_drain(1);

        $display("[TB] directed word and halfword accesses");
        apply_stimulus(0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h10, 32'd0);
        wait_drain(0);
        check_output("a_mem_byte_0x10", {24'd0, dut_a.u_array.mem[16]}, 32'h0000_00DE);
        apply_stimulus(0, 1'b1, SZ_HALF, 32'h22, 32'h5555_8001);
        apply_stimulus(0, 1'b0, SZ_HALF, 32'h22, 32'd0);
        apply_stimulus(0, 1'b0, SZ_HALFU, 32'h22, 32'd0);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h20, 32'd0);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h12, 32'd0);
        apply_stimulus(0, 1'b0, SZ_HALF, 32'h13, 32'd0);
        apply_stimulus(0, 1'b0, SZ_ILLEGAL, 32'h00, 32'd0);
        apply_stimulus(0, 1'b1, SZ_WORD, 32'h3FE, 32'hCAFE_F00D);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h3FC, 32'd0);
        apply_stimulus(0, 1'b1, SZ_HALFU, 32'h3FE, 32'h0000_A5C3);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h3FC, 32'd0);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h400, 32'd0);
        apply_stimulus(0, 1'b0, SZ_HALF, 32'hFFFF_FFFE, 32'd0);
        wait_drain(0);

        $display("[TB] response back-pressure");
        a_if.rsp_ready = 1'b0;
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h20, 32'd0);
        n = 0;
        while (!a_if.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.rsp_valid) fail_now("hold_valid_timeout");
        repeat (5) begin
            check_output("hold_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd1);
            check_output("hold_req_ready", {31'd0, a_if.req_ready}, 32'd0);
            set_req(0, 1'b1, 1'b1, SZ_WORD, 32'h0, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        set_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        a_if.rsp_ready = 1'b1;
        @(negedge clk);
        check_output("hold_release_req_ready", {31'd0, a_if.req_ready}, 32'd1);
        check_output("hold_release_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd0);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h0, 32'd0);
        wait_drain(0);

        $display("[TB] reset during wait");
        set_req(0, 1'b1, 1'b1, SZ_WORD, 32'h40, 32'h1234_5678);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        check_output("wait_req_ready", {31'd0, a_if.req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check_output("midrst_req_ready", {31'd0, a_if.req_ready}, 32'd1);
        check_output("midrst_rsp_valid", {31'd0, a_if.rsp_valid}, 32'd0);
        check_output("midrst_rsp_rdata", a_if.rsp_rdata, 32'd0);
        check_output("midrst_rsp_error", {31'd0, a_if.rsp_error}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 1'b0, SZ_WORD, 32'h40, 32'd0);
        wait_drain(0);

        $display("[TB] random traffic with random back-pressure");
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) rand_op(0);
        rand_ready = 1'b0;
        @(negedge clk);
        a_if.rsp_ready = 1'b1;
        wait_drain(0);
        for (int i = 0; i < 32; i++) apply_stimulus(0, 1'b0, SZ_WORD, 32'(i * 4), 32'd0);
        wait_drain(0);

        $display("[TB] zero-wait-state streaming");
        rand_op(1);
        first = last_acc;
        for (int i = 1; i < 60; i++) rand_op(1);
        check_output("b_throughput", 32'(last_acc - first), 32'(2 * 59));
        wait_drain(1);
        for (int i = 0; i < 32; i++) apply_stimulus(1, 1'b0, SZ_WORD, 32'(i * 4), 32'd0);
        wait_drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Memory-side responder for the CPU's data-memory load/store port; turns the single-cycle access model into a valid/ready request/response protocol with programmable wait states.
- Holds a big-endian byte-addressed data array. Serves word loads/stores, signed and unsigned halfword loads, and halfword stores.
- Sits between the CPU (or a future multi-cycle datapath) and data storage.
- Same size encoding as the CPU control unit's memRead field: 1 = word, 2 = half signed, 3 = half unsigned.

Parameters:
- DEPTH_BYTES, 1024: number of bytes in the data array; must be a multiple of 4.
- WAIT_STATES, 2: extra cycles between request accept and response; range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = illegal, 1 = word, 2 = half signed, 3 = half unsigned (for stores, 2 and 3 both mean halfword).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; a halfword store uses bits [15:0].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_error  output  1  request rejected: misaligned, out of range, or size 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, wait counter = 0.
  - Array contents are not cleared.
  - Reset during WAIT or RESP abandons the transaction. A pending store that has not yet committed is dropped.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch write, size, addr and wdata. Go to WAIT if WAIT_STATES > 0, else go to RESP.
  - WAIT: req_ready = 0. The counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to RESP.
  - RESP entry cycle (registered):
    - Perform the access and drive rsp_valid = 1, rsp_rdata and rsp_error.
    - A store commits to the array on the clock edge entering RESP.
  - RESP hold: rsp_valid, rsp_rdata and rsp_error stay stable until rsp_valid & rsp_ready.
  - On that handshake edge, return to IDLE, clear rsp_valid, and zero rsp_rdata and rsp_error.
- Latency: accept edge to rsp_valid high = WAIT_STATES+1 cycles. Minimum request-to-request spacing = WAIT_STATES+2 cycles. No back-to-back accept in the RESP handshake cycle.
- Byte order is big-endian:
  - Word at a: bits [31:24] = mem[a], [23:16] = mem[a+1], [15:8] = mem[a+2], [7:0] = mem[a+3].
  - Half at a: bits [15:8] = mem[a], [7:0] = mem[a+1].
- Load extension:
  - Size 2: sign-extend from bit 15 of the assembled halfword (the MSB of mem[a]).
  - Size 3: zero-extend.
- Error conditions (set rsp_error = 1, no array write, rsp_rdata = 0):
  - size = 0.
  - size 1 with addr[1:0] != 0.
  - size 2 or 3 with addr[0] != 0.
  - addr + access_bytes > DEPTH_BYTES, evaluated on the full 32-bit address with no wrap.
- Error responses use the same latency and handshake as good responses.
- Inputs are ignored outside the IDLE accept cycle. req_* may change freely while req_ready = 0.
- A store followed by a load to the same address must return the stored data.

Decomposition:
- Shared package mips_mem_pkg:
  - Size encoding constants SZ_ILLEGAL = 0, SZ_WORD = 1, SZ_HALF = 2, SZ_HALFU = 3.
  - State enum {IDLE, WAIT, RESP}.
  - Constant function access_bytes(size).
- Sub-module mips_dmem_array:
  - Byte array of DEPTH_BYTES entries.
  - Synchronous write with 4-bit byte-lane enable.
  - Combinational big-endian 32-bit read at a word-aligned index.
  - The responder handles halfword lane selection and extension.

Test Plan:
- WAIT_STATES = 2. Store word 0xDEADBEEF to 0x10, then load word from 0x10:
  - each rsp_valid rises 3 cycles after accept;
  - the load returns 0xDEADBEEF with rsp_error = 0;
  - mem[0x10] = 0xDE.
- Store half 0x8001 to 0x22:
  - half-signed load from 0x22 returns 0xFFFF8001;
  - half-unsigned load returns 0x00008001;
  - word load from 0x20 returns bytes 0x20-0x21 unchanged with 0x8001 in the low half.
- Misaligned and illegal requests: word load at 0x12, half load at 0x13, size 0 at 0x00, word store at 0x3FE:
  - each gives rsp_error = 1 and rsp_rdata = 0;
  - the array is unchanged (verified by a follow-up word load from 0x3FC).
- Hold rsp_ready = 0 for 5 cycles after rsp_valid rises:
  - rsp_valid, rsp_rdata and rsp_error stay stable;
  - req_ready stays 0 and a req_valid pulse is not accepted;
  - after rsp_ready = 1 for one cycle, the next cycle returns to IDLE with req_ready = 1.
- Assert reset mid-WAIT during a word store of 0x12345678 to 0x40:
  - outputs go to reset values immediately;
  - after release, a word load from 0x40 returns the prior contents.
- WAIT_STATES = 0: rsp_valid appears 1 cycle after accept; continuous traffic with rsp_ready tied high sustains one transaction every 2 cycles.
